// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the 6-bit PC and steps it through fetch/execute phases.
// Fetch uses a req/ack handshake to instruction memory and a done handshake from the datapath.
module fetch_sequencer #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req,
    output logic [5:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [5:0]         branch_target,
    output logic [5:0]         pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] pc_q;
    logic       halt_pending;
    logic       fetch_hit;
    logic       exec_hit;

    // Handshakes: imem_req stays high with a stable imem_addr until the cycle
    // imem_ack is seen (transfer on that edge); exec_done completes the current
    // instruction on the edge it is sampled. Both are ignored outside their phase.
    assign fetch_hit = (state == FETCH) && imem_ack;
    assign exec_hit  = (state == EXEC) && exec_done;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = FETCH;
            FETCH:   if (imem_ack)  state_next = EXEC;
            EXEC:    if (exec_done) state_next = (halt_pending || halt_req) ? HALT : FETCH;
            HALT:    if (start)     state_next = FETCH;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc_q         <= 6'd0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            halt_pending <= 1'b0;
            retired      <= '0;
        end else begin
            state       <= state_next;
            instr_valid <= fetch_hit;
            if (fetch_hit) begin
                instr <= imem_rdata;
            end
            if (exec_hit) begin
                pc_q    <= branch_taken ? branch_target : pc_q + 6'd1;
                retired <= retired + CNT_W'(1);
            end
            // Entering (or sitting in) HALT consumes the pending request.
            if (state_next == HALT) begin
                halt_pending <= 1'b0;
            end else if (halt_req && (state == FETCH || state == EXEC)) begin
                halt_pending <= 1'b1;
            end
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign busy      = (state == FETCH) || (state == EXEC);
    assign halted    = (state == HALT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the 6-bit program counter and sequences it through fetch and execute phases. It issues requests to instruction memory with a req/ack handshake, hands each fetched word to the datapath, and waits for the datapath to report completion. On completion it advances the PC sequentially or loads a branch target. It supports start, sticky halt and a retired-instruction count, and sits between instruction memory and the execute datapath.

## Interface
- INSTR_W, 32, instruction word width
- CNT_W, 16, retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level/pulse; leaves IDLE or HALT, ignored otherwise
- halt_req  in  1  request to stop after current instruction completes
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  6  fetch address, equals pc
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  INSTR_W  instruction word, valid with imem_ack
- instr  out  INSTR_W  latched instruction for datapath
- instr_valid  out  1  one-cycle pulse: new instr available
- exec_done  in  1  datapath finished current instruction
- branch_taken  in  1  qualified by exec_done
- branch_target  in  6  qualified by exec_done and branch_taken
- pc  out  6  current program counter
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALT
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async): state=IDLE, pc=0, instr=0, instr_valid=0, halt_pending=0, retired=0. All outputs are low/zero.
- IDLE: imem_req=0. On start, go to FETCH. pc is unchanged.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1 (next cycle only), go to EXEC. Without ack, remain in FETCH with req held and addr stable.
- EXEC: imem_req=0. Wait for exec_done. On exec_done:
  - pc <= branch_taken ? branch_target : pc+1.
  - retired <= retired+1.
  - Next state is HALT if halt_pending or halt_req is set, else FETCH.
- pc+1 is modulo 64: pc 63 wraps to 0. retired wraps at 2^CNT_W-1 to 0.
- HALT: imem_req=0 and halted=1. pc keeps the already-advanced value. On start: clear halt_pending, go to FETCH, resume at pc.
- halt_pending: set when halt_req=1 in FETCH or EXEC. Cleared on entry to HALT. halt_req in IDLE or HALT is ignored.
- Inputs ignored outside their state:
  - imem_ack outside FETCH.
  - exec_done, branch_taken and branch_target outside EXEC.
  - start in FETCH or EXEC.
- Simultaneous halt_req and start in HALT: start wins, halt_req is ignored.

## Timing
- imem_req, imem_addr, busy and halted are decoded from the registered state and pc. They are valid in the same cycle the state is entered.
- Ack to instr_valid: instr and instr_valid are registered at the ack edge. instr_valid is high for exactly the first EXEC cycle.
- exec_done may be asserted in that same first EXEC cycle, giving single-cycle execution.
- Minimum throughput is 2 cycles per instruction: ack in the first FETCH cycle, done in the first EXEC cycle.
- Start latency: start sampled at edge N gives imem_req=1 from cycle N+1.
- Halt latency: HALT is entered at the edge that samples exec_done. halted=1 in the following cycle.
- Asynchronous rst mid-fetch: imem_req drops immediately (combinational from state). No pc update, no retired increment.

## Test plan
- Reset then start, ack immediate, exec_done immediate for 3 instructions:
  - imem_addr goes 0, 1, 2.
  - instr_valid pulses once per instruction.
  - retired=3.
  - 2 cycles per instruction.
- Fetch stall: hold imem_ack low for 4 cycles at pc=5. imem_req stays 1 and imem_addr stays 5 throughout. instr_valid only after ack. rdata=0xDEADBEEF appears on instr.
- Branch: at pc=10, exec_done with branch_taken=1 and target=40. Next imem_addr=40 and retired increments. Second case: branch_taken=0 at pc=63 gives next imem_addr=0 (wrap).
- Halt: pulse halt_req during FETCH at pc=7, then ack and exec_done.
  - HALT entered with pc=8, halted=1, no imem_req.
  - start gives fetch at 8 and halted=0.
- Ignored inputs:
  - start during EXEC has no effect.
  - exec_done during FETCH does not advance pc.
  - imem_ack in IDLE does not change instr.
- Async rst asserted mid-EXEC at pc=20 with retired=5: outputs clear to pc=0, retired=0, IDLE before the next clock edge.
